// File: rtl/swd_pkg.sv
// Shared types and constants for the SWD bit engine.
package swd_pkg;

  typedef enum logic [1:0] {IDLE, TURN, SHIFT, PARITY} state_t;

  localparam logic DIR_WRITE   = 1'b0;
  localparam logic DIR_READ    = 1'b1;
  localparam int   SWD_MAXBITS = 32;

endpackage

// File: rtl/swd_req_sync.sv
// Two-flop synchroniser for a level request from another clock domain,
// followed by a one-clk pulse on its rising edge.
module swd_req_sync (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= req;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign pulse = sync & ~sync_d;

endmodule

// File: rtl/swd_engine.sv
// SWD bit engine: runs one header, ACK or data phase per request, generating
// SWCLK/SWDIO and returning read data plus parity status.
module swd_engine
  import swd_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        txReq,
  input  logic        rxReq,
  input  logic        useParity,
  input  logic [4:0]  bits,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        parityOut,
  output logic        parityErr,
  output logic        busy,
  output logic        swclk,
  output logic        swdio_out,
  output logic        swdio_oe,
  input  logic        swdio_in
);

  localparam int PHW = $clog2(2 * DIV + 1);
  localparam logic [PHW-1:0] LOW_LAST = PHW'(DIV - 1);
  localparam logic [PHW-1:0] PER_LAST = PHW'(2 * DIV - 1);

  logic tx_pulse;
  logic rx_pulse;

  swd_req_sync u_tx_sync (.clk(clk), .rst(rst), .req(txReq), .pulse(tx_pulse));
  swd_req_sync u_rx_sync (.clk(clk), .rst(rst), .req(rxReq), .pulse(rx_pulse));

  state_t                 state;
  logic                   last_dir;
  logic                   op_dir;
  logic                   par_en;
  logic [4:0]             nbits;
  logic [4:0]             bit_cnt;
  logic [SWD_MAXBITS-1:0] tx_data;
  logic [SWD_MAXBITS-1:0] rx_data;
  logic [PHW-1:0]         phase;
  logic                   par_acc;
  logic                   par_smp;

  logic       end_low;
  logic       end_per;
  logic       op_done;
  logic       start_dir;
  logic [4:0] next_bit;
  logic       next_tx;

  assign end_low   = (phase == LOW_LAST);
  assign end_per   = (phase == PER_LAST);
  assign start_dir = tx_pulse ? DIR_WRITE : DIR_READ;
  assign next_bit  = bit_cnt + 5'd1;
  assign next_tx   = tx_data[next_bit];
  assign op_done   = end_per && ((state == PARITY) ||
                                 (state == SHIFT && bit_cnt == nbits && !par_en));

  // Each period starts its low phase with phase=0; drive changes land there,
  // and the target is sampled on the edge that raises swclk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_dir  <= DIR_WRITE;
      op_dir    <= DIR_WRITE;
      par_en    <= 1'b0;
      nbits     <= '0;
      bit_cnt   <= '0;
      tx_data   <= '0;
      rx_data   <= '0;
      phase     <= '0;
      par_acc   <= 1'b0;
      par_smp   <= 1'b0;
      dataOut   <= '0;
      parityOut <= 1'b0;
      parityErr <= 1'b0;
      busy      <= 1'b0;
      swclk     <= 1'b0;
      swdio_out <= 1'b0;
      swdio_oe  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (tx_pulse || rx_pulse) begin
            op_dir  <= start_dir;
            tx_data <= dataIn;
            nbits   <= bits;
            par_en  <= useParity;
            rx_data <= '0;
            bit_cnt <= '0;
            phase   <= '0;
            par_smp <= 1'b0;
            swclk   <= 1'b0;
            busy    <= 1'b1;
            if (start_dir != last_dir) begin
              state     <= TURN;
              swdio_oe  <= 1'b0;
              swdio_out <= 1'b0;
              par_acc   <= 1'b0;
            end else begin
              state     <= SHIFT;
              swdio_oe  <= (start_dir == DIR_WRITE);
              swdio_out <= (start_dir == DIR_WRITE) & dataIn[0];
              par_acc   <= (start_dir == DIR_WRITE) & dataIn[0];
            end
          end
        end
        default: begin
          phase <= end_per ? '0 : phase + 1'b1;
          if (end_low)
            swclk <= 1'b1;
          else if (end_per)
            swclk <= 1'b0;

          if (end_low && op_dir == DIR_READ) begin
            if (state == SHIFT) begin
              rx_data[bit_cnt] <= swdio_in;
              par_acc          <= par_acc ^ swdio_in;
            end
            if (state == PARITY)
              par_smp <= swdio_in;
          end

          if (end_per) begin
            case (state)
              TURN: begin
                state <= SHIFT;
                if (op_dir == DIR_WRITE) begin
                  swdio_oe  <= 1'b1;
                  swdio_out <= tx_data[0];
                  par_acc   <= tx_data[0];
                end
              end
              SHIFT: begin
                if (bit_cnt == nbits) begin
                  if (par_en) begin
                    state <= PARITY;
                    if (op_dir == DIR_WRITE)
                      swdio_out <= par_acc;
                  end
                end else begin
                  bit_cnt <= next_bit;
                  if (op_dir == DIR_WRITE) begin
                    swdio_out <= next_tx;
                    par_acc   <= par_acc ^ next_tx;
                  end
                end
              end
              default: ;
            endcase
          end

          if (op_done) begin
            state     <= IDLE;
            busy      <= 1'b0;
            last_dir  <= op_dir;
            swdio_out <= 1'b0;
            swdio_oe  <= (op_dir == DIR_WRITE);
            if (op_dir == DIR_READ) begin
              dataOut   <= rx_data;
              parityOut <= par_en ? par_smp : parityOut;
              parityErr <= par_en & (par_smp ^ par_acc);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swd_engine.sv
// Scoreboard bench for swd_engine: one DIV=2 and one DIV=1 instance, a bit-level
// target model, and a monitor that checks each completed operation.
module tb_swd_engine;

  logic clk = 1'b0;
  logic rst;
  logic a_tx, a_rx, b_tx, b_rx;
  logic useParity;
  logic [4:0] bits;
  logic [31:0] dataIn;
  logic swdio_in;
  logic sel;

  logic [31:0] a_dout, b_dout;
  logic a_pout, a_perr, a_busy, a_swclk, a_out, a_oe;
  logic b_pout, b_perr, b_busy, b_swclk, b_out, b_oe;

  swd_engine #(.DIV(2)) u_a (
    .clk(clk), .rst(rst), .txReq(a_tx), .rxReq(a_rx), .useParity(useParity),
    .bits(bits), .dataIn(dataIn), .dataOut(a_dout), .parityOut(a_pout),
    .parityErr(a_perr), .busy(a_busy), .swclk(a_swclk), .swdio_out(a_out),
    .swdio_oe(a_oe), .swdio_in(swdio_in)
  );

  swd_engine #(.DIV(1)) u_b (
    .clk(clk), .rst(rst), .txReq(b_tx), .rxReq(b_rx), .useParity(useParity),
    .bits(bits), .dataIn(dataIn), .dataOut(b_dout), .parityOut(b_pout),
    .parityErr(b_perr), .busy(b_busy), .swclk(b_swclk), .swdio_out(b_out),
    .swdio_oe(b_oe), .swdio_in(swdio_in)
  );

  always #5 clk = ~clk;

  wire [31:0] mon_dout  = sel ? b_dout  : a_dout;
  wire        mon_pout  = sel ? b_pout  : a_pout;
  wire        mon_perr  = sel ? b_perr  : a_perr;
  wire        mon_busy  = sel ? b_busy  : a_busy;
  wire        mon_swclk = sel ? b_swclk : a_swclk;
  wire        mon_out   = sel ? b_out   : a_out;
  wire        mon_oe    = sel ? b_oe    : a_oe;

  typedef struct {
    int          len;
    int          periods;
    int          nw;
    logic [39:0] wbits;
    logic [31:0] dout;
    logic        pout;
    logic        perr;
    logic        first_oe;
    logic        idle_oe;
  } exp_t;

  exp_t sb[$];
  logic tgt[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_op(input int len, input int periods, input int nw,
                           input logic [39:0] wbits, input logic [31:0] dout,
                           input logic pout, input logic perr,
                           input logic first_oe, input logic idle_oe);
    exp_t e;
    e.len = len; e.periods = periods; e.nw = nw; e.wbits = wbits; e.dout = dout;
    e.pout = pout; e.perr = perr; e.first_oe = first_oe; e.idle_oe = idle_oe;
    sb.push_back(e);
  endtask

  task automatic load_target(input logic [39:0] v, input int n);
    tgt.delete();
    for (int i = 0; i < n; i++) tgt.push_back(v[i]);
  endtask

  // Target answers one bit per swclk period while the host is not driving.
  always @(posedge mon_swclk)
    if (mon_busy && !mon_oe && tgt.size() > 0) void'(tgt.pop_front());

  always @(negedge clk)
    swdio_in = (tgt.size() > 0) ? tgt[0] : 1'b0;

  int          m_len, m_periods, m_nw;
  logic [39:0] m_wbits;
  logic        m_first_oe;
  logic        prev_busy = 1'b0;
  logic        prev_swclk = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_busy  = 1'b0;
      prev_swclk = 1'b0;
    end else begin
      if (mon_busy && !prev_busy) begin
        m_len = 0; m_periods = 0; m_nw = 0; m_wbits = '0; m_first_oe = 1'b1;
      end
      if (mon_busy) begin
        m_len++;
        if (mon_swclk && !prev_swclk) begin
          if (m_periods == 0) m_first_oe = mon_oe;
          if (mon_oe && m_nw < 40) begin
            m_wbits[m_nw] = mon_out;
            m_nw++;
          end
          m_periods++;
        end
      end
      if (!mon_busy && prev_busy) begin
        if (sb.size() == 0) begin
          check("unexpected_op", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("busy_len",   m_len,      e.len);
          check("periods",    m_periods,  e.periods);
          check("wbits_n",    m_nw,       e.nw);
          check("wbits",      m_wbits,    e.wbits);
          check("first_oe",   m_first_oe, e.first_oe);
          check("dataOut",    mon_dout,   e.dout);
          check("parityOut",  mon_pout,   e.pout);
          check("parityErr",  mon_perr,   e.perr);
          check("idle_oe",    mon_oe,     e.idle_oe);
          check("idle_swclk", mon_swclk,  0);
          check("idle_out",   mon_out,    0);
        end
      end
      prev_busy  = mon_busy;
      prev_swclk = mon_swclk;
    end
  end

  task automatic apply_op(input logic unit, input logic wr, input logic rd,
                          input logic [4:0] nb, input logic par,
                          input logic [31:0] data, input logic retrig);
    int n;
    @(negedge clk);
    bits = nb; useParity = par; dataIn = data;
    if (unit) begin b_tx = wr; b_rx = rd; end
    else      begin a_tx = wr; a_rx = rd; end
    @(negedge clk);
    @(negedge clk);
    check("busy_early", mon_busy, 0);
    @(negedge clk);
    check("busy_rise", mon_busy, 1);
    dataIn = ~data; bits = ~nb; useParity = ~par;
    a_tx = 0; a_rx = 0; b_tx = 0; b_rx = 0;
    if (retrig) begin
      repeat (4) @(negedge clk);
      if (unit) b_tx = 1; else a_tx = 1;
      repeat (6) @(negedge clk);
      a_tx = 0; b_tx = 0;
    end
    n = 0;
    while (mon_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("busy_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1; sel = 0;
    a_tx = 0; a_rx = 0; b_tx = 0; b_rx = 0;
    useParity = 0; bits = '0; dataIn = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_busy",  a_busy,  0);
    check("rst_swclk", a_swclk, 0);
    check("rst_oe",    a_oe,    1);
    check("rst_out",   a_out,   0);
    check("rst_dout",  a_dout,  0);
    check("rst_pout",  a_pout,  0);
    check("rst_perr",  a_perr,  0);

    // 32-bit write with parity straight from reset: no turnaround
    expect_op(132, 33, 33, 40'h1_1234_5678, 32'h0, 0, 0, 1, 1);
    apply_op(0, 1, 0, 5'd31, 1, 32'h1234_5678, 0);

    // 3-bit read after a write: turnaround, then 1,0,0
    load_target(40'h2, 4);
    expect_op(16, 4, 0, 40'h0, 32'h1, 0, 0, 0, 0);
    apply_op(0, 0, 1, 5'd2, 0, 32'hFFFF_FFFF, 0);

    // 32-bit read with a wrong parity bit
    load_target(40'h1_DEAD_BEEF, 33);
    expect_op(132, 33, 0, 40'h0, 32'hDEAD_BEEF, 1, 1, 0, 0);
    apply_op(0, 0, 1, 5'd31, 1, 32'h0, 0);

    // Simultaneous requests: write wins; a retrigger during busy is dropped
    expect_op(20, 5, 4, 40'h9, 32'hDEAD_BEEF, 1, 1, 0, 1);
    apply_op(0, 1, 1, 5'd3, 0, 32'h9, 1);
    repeat (30) @(negedge clk);

    // Reset in the middle of a write
    @(negedge clk);
    bits = 5'd31; useParity = 0; dataIn = 32'hFFFF_FFFF; a_tx = 1;
    n = 0;
    while (!(mon_busy && m_periods == 10) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("mid_timeout", 1, 0);
    check("pre_rst_out", a_out, 1);
    rst = 1; a_tx = 0;
    #1;
    check("abort_busy",  a_busy,  0);
    check("abort_swclk", a_swclk, 0);
    check("abort_oe",    a_oe,    1);
    check("abort_out",   a_out,   0);
    check("abort_dout",  a_dout,  0);
    repeat (2) @(negedge clk);
    rst = 0;
    expect_op(16, 4, 4, 40'h6, 32'h0, 0, 0, 1, 1);
    apply_op(0, 1, 0, 5'd3, 0, 32'h6, 0);

    // DIV=1 byte write
    sel = 1;
    expect_op(16, 8, 8, 40'hA5, 32'h0, 0, 0, 1, 1);
    apply_op(1, 1, 0, 5'd7, 0, 32'hA5, 0);

    repeat (10) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
